// File: rtl/csr_bus_responder.sv
// csr_bus_responder
//   Machine-mode CSR file answering the pipeline's CSR read/write bus and
//   absorbing trap-entry / trap-return events from commit.
//
//   Ports
//     clk, reset (async, active low)
//     csrbus_ar*/r*  : read request (always accepted) and one-cycle response
//     csrbus_w*/b*   : write request and held write response
//     exception_*_in : trap entry event and its pc/cause/value
//     mret_valid_in  : trap return event
//     exception_mtvec_base_out, exception_mepc_out, global_irq_en_out :
//                      combinational views of mtvec, mepc and mstatus.MIE
//
//   Build option
//     CSR_COUNTERS_EN : adds the 64-bit mcycle counter at 0xB00/0xB80
//                       (read/write) with read-only mirrors at 0xC00/0xC80.
//                       Without it those addresses are unimplemented.
module csr_bus_responder #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [11:0] csrbus_araddr,
    input  logic        csrbus_arvalid,
    output logic [31:0] csrbus_rdata,
    output logic [1:0]  csrbus_rresp,
    output logic        csrbus_rvalid,

    input  logic [11:0] csrbus_waddr,
    input  logic [31:0] csrbus_wdata,
    input  logic        csrbus_wvalid,
    output logic        csrbus_wready,
    output logic [2:0]  csrbus_bresp,
    output logic        csrbus_bvalid,
    input  logic        csrbus_bready,

    input  logic        exception_valid_in,
    input  logic [31:0] exception_mepc_in,
    input  logic [31:0] exception_mcause_in,
    input  logic [31:0] exception_mtval_in,
    input  logic        mret_valid_in,

    output logic [29:0] exception_mtvec_base_out,
    output logic [31:0] exception_mepc_out,
    output logic        global_irq_en_out
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MHARTID  = 12'hF14;
`ifdef CSR_COUNTERS_EN
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_CYCLEH   = 12'hC80;
`endif

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [2:0] BRESP_OKAY   = 3'b000;
    localparam logic [2:0] BRESP_UNIMPL = 3'b010;
    localparam logic [2:0] BRESP_RO     = 3'b011;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    w_state_t    w_state, w_next;

    logic        st_mie, st_mpie;
    logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [2:0]  bresp_q;

    logic [31:0] rd_val;
    logic        rd_err;
    logic [2:0]  wr_resp;
    logic        wr_fire;

`ifdef CSR_COUNTERS_EN
    logic [31:0] cyc_lo, cyc_hi;
`endif

    // ---------------- read decode ----------------
    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        case (csrbus_araddr)
            A_MSTATUS:  rd_val = {24'b0, st_mpie, 3'b0, st_mie, 3'b0};
            A_MISA:     rd_val = MISA_VAL;
            A_MIE:      rd_val = mie_q;
            A_MTVEC:    rd_val = mtvec_q;
            A_MSCRATCH: rd_val = mscratch_q;
            A_MEPC:     rd_val = mepc_q;
            A_MCAUSE:   rd_val = mcause_q;
            A_MTVAL:    rd_val = mtval_q;
            A_MHARTID:  rd_val = '0;
`ifdef CSR_COUNTERS_EN
            A_MCYCLE,  A_CYCLE:  rd_val = cyc_lo;
            A_MCYCLEH, A_CYCLEH: rd_val = cyc_hi;
`endif
            default:    rd_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csrbus_rvalid <= 1'b0;
            csrbus_rdata  <= '0;
            csrbus_rresp  <= RRESP_OKAY;
        end else begin
            csrbus_rvalid <= csrbus_arvalid;
            if (csrbus_arvalid) begin
                csrbus_rdata <= rd_val;
                csrbus_rresp <= rd_err ? RRESP_SLVERR : RRESP_OKAY;
            end
        end
    end

    // ---------------- write decode and FSM ----------------
    always_comb begin
        wr_resp = BRESP_OKAY;
        case (csrbus_waddr)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH,
            A_MEPC, A_MCAUSE, A_MTVAL:            wr_resp = BRESP_OKAY;
            A_MISA, A_MHARTID:                    wr_resp = BRESP_RO;
`ifdef CSR_COUNTERS_EN
            A_MCYCLE, A_MCYCLEH:                  wr_resp = BRESP_OKAY;
            A_CYCLE, A_CYCLEH:                    wr_resp = BRESP_RO;
`endif
            default:                              wr_resp = BRESP_UNIMPL;
        endcase
    end

    assign wr_fire = (w_state == W_IDLE) && csrbus_wvalid && (wr_resp == BRESP_OKAY);

    always_comb begin
        w_next        = w_state;
        csrbus_wready = 1'b0;
        csrbus_bvalid = 1'b0;
        case (w_state)
            W_IDLE: begin
                csrbus_wready = 1'b1;
                if (csrbus_wvalid) w_next = W_RESP;
            end
            W_RESP: begin
                csrbus_bvalid = 1'b1;
                if (csrbus_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state <= W_IDLE;
            bresp_q <= BRESP_OKAY;
        end else begin
            w_state <= w_next;
            if (w_state == W_IDLE && csrbus_wvalid) bresp_q <= wr_resp;
        end
    end

    assign csrbus_bresp = bresp_q;

    // ---------------- CSR state ----------------
    // Trap events own mstatus/mepc/mcause/mtval in their cycle; a bus write
    // to those fields is dropped there but still acknowledged OKAY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= RESET_MTVEC & 32'hFFFF_FFFC;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            if (exception_valid_in) begin
                mepc_q   <= exception_mepc_in & 32'hFFFF_FFFC;
                mcause_q <= exception_mcause_in;
                mtval_q  <= exception_mtval_in;
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
            end else begin
                if (mret_valid_in) begin
                    st_mie  <= st_mpie;
                    st_mpie <= 1'b1;
                end else if (wr_fire && csrbus_waddr == A_MSTATUS) begin
                    st_mie  <= csrbus_wdata[3];
                    st_mpie <= csrbus_wdata[7];
                end
                if (wr_fire && csrbus_waddr == A_MEPC)   mepc_q   <= csrbus_wdata & 32'hFFFF_FFFC;
                if (wr_fire && csrbus_waddr == A_MCAUSE) mcause_q <= csrbus_wdata;
                if (wr_fire && csrbus_waddr == A_MTVAL)  mtval_q  <= csrbus_wdata;
            end
            if (wr_fire && csrbus_waddr == A_MIE)      mie_q      <= csrbus_wdata;
            if (wr_fire && csrbus_waddr == A_MTVEC)    mtvec_q    <= csrbus_wdata & 32'hFFFF_FFFC;
            if (wr_fire && csrbus_waddr == A_MSCRATCH) mscratch_q <= csrbus_wdata;
        end
    end

`ifdef CSR_COUNTERS_EN
    // Writing one half replaces it without increment; the other half still
    // takes its normal increment/carry from the old count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_lo <= '0;
            cyc_hi <= '0;
        end else if (wr_fire && csrbus_waddr == A_MCYCLE) begin
            cyc_lo <= csrbus_wdata;
            cyc_hi <= cyc_hi + {31'b0, &cyc_lo};
        end else if (wr_fire && csrbus_waddr == A_MCYCLEH) begin
            cyc_hi <= csrbus_wdata;
            cyc_lo <= cyc_lo + 32'd1;
        end else begin
            {cyc_hi, cyc_lo} <= {cyc_hi, cyc_lo} + 64'd1;
        end
    end
`endif

    assign exception_mtvec_base_out = mtvec_q[31:2];
    assign exception_mepc_out       = mepc_q;
    assign global_irq_en_out        = st_mie;

endmodule
